imba_menu_sequencer: RTL and testbench

Menu and layer sequencer for the overlay renderer. Decides what the background-draw stage shows on each frame: welcome screen, plain graph, or graph with menu and cursor. It also owns the Axis/Grid/Tick enables and flashes a selection box on confirm. Button events update internal "live" state immediately. All renderer-facing outputs are shadow registers committed only on `frame_tick`, so a frame never changes mid-scan.

---
 rtl/imba_menu_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_imba_menu_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imba_menu_sequencer.sv
// Menu/layer sequencer for the overlay renderer: live state follows buttons at once,
// renderer-facing outputs are shadow registers committed only on frame_tick.
module imba_menu_sequencer #(
   parameter int unsigned WELCOME_FRAMES = 180,
   parameter int unsigned FLASH_FRAMES   = 30,
   parameter int unsigned MENU_TIMEOUT   = 600
) (
   input  logic       CLK_VGA,
   input  logic       RESET,
   input  logic       frame_tick,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_centre,
   output logic       Axis_On,
   output logic       Grid_On,
   output logic       Tick_On,
   output logic       Welcome_On,
   output logic       Menu_On,
   output logic [1:0] Cursor_Pos,
   output logic [3:0] Box_Flash
);

   localparam int unsigned CNT_W = 10;

   localparam logic [CNT_W-1:0] WELCOME_LAST = CNT_W'(WELCOME_FRAMES - 1);
   localparam logic [CNT_W-1:0] FLASH_LAST   = CNT_W'(FLASH_FRAMES - 1);
   localparam logic [CNT_W-1:0] MENU_LAST    = CNT_W'(MENU_TIMEOUT - 1);

   localparam logic [1:0] ST_WELCOME = 2'd0;
   localparam logic [1:0] ST_IDLE    = 2'd1;
   localparam logic [1:0] ST_MENU    = 2'd2;
   localparam logic [1:0] ST_CONFIRM = 2'd3;

   // layer bit order: [0] axis, [1] grid, [2] tick
   localparam logic [2:0] LAYERS_RST = 3'b101;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;
   logic [1:0]       cursor_q, cursor_d;
   logic [1:0]       sel_q, sel_d;
   logic [2:0]       layers_q, layers_d;

   logic       axis_on_q, grid_on_q, tick_on_q;
   logic       welcome_on_q, menu_on_q;
   logic [1:0] cursor_pos_q;
   logic [3:0] box_flash_q;

   logic       move_up_c, move_down_c;
   logic       flash_on_c;
   logic [3:0] box_d;

   assign move_up_c   = btn_up   & ~btn_down & ~btn_centre;
   assign move_down_c = btn_down & ~btn_up   & ~btn_centre;

   // State register and live menu state
   always_ff @(posedge CLK_VGA or posedge RESET) begin
      if (RESET) begin
         state_q  <= ST_WELCOME;
         fcnt_q   <= '0;
         cursor_q <= 2'd0;
         sel_q    <= 2'd0;
         layers_q <= LAYERS_RST;
      end else begin
         state_q  <= state_d;
         fcnt_q   <= fcnt_d;
         cursor_q <= cursor_d;
         sel_q    <= sel_d;
         layers_q <= layers_d;
      end
   end

   // Next-state, frame counter and live state updates
   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      cursor_d = cursor_q;
      sel_d    = sel_q;
      layers_d = layers_q;

      case (state_q)
         ST_WELCOME: begin
            if (btn_centre) begin
               state_d = ST_IDLE;
               fcnt_d  = '0;
            end else if (frame_tick) begin
               if (fcnt_q == WELCOME_LAST) begin
                  state_d = ST_IDLE;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = fcnt_q + CNT_W'(1);
               end
            end
         end

         ST_IDLE: begin
            if (btn_centre) begin
               state_d = ST_MENU;
               fcnt_d  = '0;
            end else if (frame_tick) begin
               fcnt_d = fcnt_q + CNT_W'(1);
            end
         end

         ST_MENU: begin
            // an accepted button clears the counter, which also cancels a coincident timeout
            if (btn_centre) begin
               sel_d   = cursor_q;
               state_d = ST_CONFIRM;
               fcnt_d  = '0;
            end else if (move_up_c) begin
               cursor_d = cursor_q - 2'd1;
               fcnt_d   = '0;
            end else if (move_down_c) begin
               cursor_d = cursor_q + 2'd1;
               fcnt_d   = '0;
            end else if (frame_tick) begin
               if (fcnt_q == MENU_LAST) begin
                  state_d = ST_IDLE;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = fcnt_q + CNT_W'(1);
               end
            end
         end

         ST_CONFIRM: begin
            if (frame_tick) begin
               if (fcnt_q == FLASH_LAST) begin
                  fcnt_d = '0;
                  case (sel_q)
                     2'd0:    begin layers_d[0] = ~layers_q[0]; state_d = ST_MENU; end
                     2'd1:    begin layers_d[1] = ~layers_q[1]; state_d = ST_MENU; end
                     2'd2:    begin layers_d[2] = ~layers_q[2]; state_d = ST_MENU; end
                     default: state_d = ST_IDLE;
                  endcase
               end else begin
                  fcnt_d = fcnt_q + CNT_W'(1);
               end
            end
         end

         default: begin
            state_d = ST_WELCOME;
            fcnt_d  = '0;
         end
      endcase
   end

   // Flash phase follows the frame count at the start of the frame; a fresh entry starts lit.
   assign flash_on_c = (state_d == ST_CONFIRM) &&
                       ((state_q != ST_CONFIRM) || (fcnt_q[2] == 1'b0));
   assign box_d      = flash_on_c ? (4'b0001 << sel_d) : 4'b0000;

   // Shadow registers committed once per frame from the freshly computed live state
   always_ff @(posedge CLK_VGA or posedge RESET) begin
      if (RESET) begin
         axis_on_q    <= LAYERS_RST[0];
         grid_on_q    <= LAYERS_RST[1];
         tick_on_q    <= LAYERS_RST[2];
         welcome_on_q <= 1'b1;
         menu_on_q    <= 1'b0;
         cursor_pos_q <= 2'd0;
         box_flash_q  <= 4'b0000;
      end else if (frame_tick) begin
         axis_on_q    <= layers_d[0];
         grid_on_q    <= layers_d[1];
         tick_on_q    <= layers_d[2];
         welcome_on_q <= (state_d == ST_WELCOME);
         menu_on_q    <= (state_d == ST_MENU) || (state_d == ST_CONFIRM);
         cursor_pos_q <= cursor_d;
         box_flash_q  <= box_d;
      end
   end

   assign Axis_On    = axis_on_q;
   assign Grid_On    = grid_on_q;
   assign Tick_On    = tick_on_q;
   assign Welcome_On = welcome_on_q;
   assign Menu_On    = menu_on_q;
   assign Cursor_Pos = cursor_pos_q;
   assign Box_Flash  = box_flash_q;

endmodule

// File: tb/tb_imba_menu_sequencer.sv
// Bench for imba_menu_sequencer: behavioural frame model checked every cycle plus
// hand-computed expectations at the scenario checkpoints.
module tb_imba_menu_sequencer;

   localparam int unsigned WF = 4;
   localparam int unsigned FF = 8;
   localparam int unsigned MT = 6;

   localparam int M_WEL  = 0;
   localparam int M_IDLE = 1;
   localparam int M_MENU = 2;
   localparam int M_CONF = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       ft, bu, bd, bc;
   logic       axis_on, grid_on, tick_on, welcome_on, menu_on;
   logic [1:0] cursor_pos;
   logic [3:0] box_flash;

   int n_cmp = 0;
   int n_bad = 0;
   bit started = 1'b0;

   // model: live state
   int m_st, m_cnt, m_cur, m_sel;
   bit m_lay [3];
   // model: what the renderer should be showing
   bit s_axis, s_grid, s_tick, s_wel, s_menu;
   int s_cur, s_box;

   imba_menu_sequencer #(
      .WELCOME_FRAMES(WF),
      .FLASH_FRAMES  (FF),
      .MENU_TIMEOUT  (MT)
   ) dut (
      .CLK_VGA   (clk),
      .RESET     (rst),
      .frame_tick(ft),
      .btn_up    (bu),
      .btn_down  (bd),
      .btn_centre(bc),
      .Axis_On   (axis_on),
      .Grid_On   (grid_on),
      .Tick_On   (tick_on),
      .Welcome_On(welcome_on),
      .Menu_On   (menu_on),
      .Cursor_Pos(cursor_pos),
      .Box_Flash (box_flash)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_st = M_WEL; m_cnt = 0; m_cur = 0; m_sel = 0;
      m_lay[0] = 1'b1; m_lay[1] = 1'b0; m_lay[2] = 1'b1;
      s_axis = 1'b1; s_grid = 1'b0; s_tick = 1'b1;
      s_wel = 1'b1; s_menu = 1'b0; s_cur = 0; s_box = 0;
   endtask

   task automatic enter(input int st);
      m_st  = st;
      m_cnt = 0;
   endtask

   // One clock of live behaviour, then the frame commit if this cycle carries a tick.
   task automatic model_step(input bit u, input bit d, input bit c, input bit t);
      int pst, pcnt, phase;
      pst  = m_st;
      pcnt = m_cnt;
      case (m_st)
         M_WEL: begin
            if (c) enter(M_IDLE);
            else if (t) begin
               if (m_cnt + 1 == int'(WF)) enter(M_IDLE);
               else m_cnt++;
            end
         end
         M_IDLE: begin
            if (c) enter(M_MENU);
            else if (t) m_cnt++;
         end
         M_MENU: begin
            if (c) begin
               m_sel = m_cur;
               enter(M_CONF);
            end else if (u != d) begin
               m_cur = (m_cur + (u ? 3 : 1)) % 4;
               m_cnt = 0;
            end else if (t) begin
               if (m_cnt + 1 == int'(MT)) enter(M_IDLE);
               else m_cnt++;
            end
         end
         default: begin
            if (t) begin
               if (m_cnt + 1 == int'(FF)) begin
                  if (m_sel == 3) enter(M_IDLE);
                  else begin
                     m_lay[m_sel] = ~m_lay[m_sel];
                     enter(M_MENU);
                  end
               end else m_cnt++;
            end
         end
      endcase
      if (t) begin
         s_axis = m_lay[0];
         s_grid = m_lay[1];
         s_tick = m_lay[2];
         s_wel  = (m_st == M_WEL);
         s_menu = (m_st == M_MENU) || (m_st == M_CONF);
         s_cur  = m_cur;
         s_box  = 0;
         if (m_st == M_CONF) begin
            phase = (pst == M_CONF) ? pcnt : 0;
            if ((phase / 4) % 2 == 0) s_box = 1 << m_sel;
         end
      end
   endtask

   // Every cycle: all renderer outputs against the model
   always @(negedge clk) begin
      if (started) begin
         chk("Axis_On",    int'(axis_on),    int'(s_axis));
         chk("Grid_On",    int'(grid_on),    int'(s_grid));
         chk("Tick_On",    int'(tick_on),    int'(s_tick));
         chk("Welcome_On", int'(welcome_on), int'(s_wel));
         chk("Menu_On",    int'(menu_on),    int'(s_menu));
         chk("Cursor_Pos", int'(cursor_pos), s_cur);
         chk("Box_Flash",  int'(box_flash),  s_box);
      end
   end

   task automatic step(input bit u, input bit d, input bit c, input bit t);
      bu = u; bd = d; bc = c; ft = t;
      @(posedge clk);
      model_step(u, d, c, t);
      #1;
      bu = 1'b0; bd = 1'b0; bc = 1'b0; ft = 1'b0;
      @(negedge clk);
      #2;
   endtask

   task automatic tick();
      step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rst = 1'b1; ft = 1'b0; bu = 1'b0; bd = 1'b0; bc = 1'b0;
      model_reset();
      started = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      chk("rst Welcome_On", int'(welcome_on), 1);
      chk("rst Axis_On",    int'(axis_on),    1);
      chk("rst Grid_On",    int'(grid_on),    0);
      rst = 1'b0;

      // welcome auto-advance after 4 frames
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("welcome hold", int'(welcome_on), (k < 4) ? 1 : 0);
         chk("welcome menu", int'(menu_on), 0);
      end

      // into menu, cursor wraps and is frame-gated
      step(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk("menu entry", int'(menu_on), 1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("cursor gated", int'(cursor_pos), 0);
      tick();
      chk("cursor wrap up", int'(cursor_pos), 3);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("cursor wrap down", int'(cursor_pos), 0);

      // grid toggle with 8-frame flash
      step(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("cursor grid", int'(cursor_pos), 1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         tick();
         chk("grid flash", int'(box_flash), (k <= 4) ? 2 : 0);
         chk("grid on", int'(grid_on), (k == 8) ? 1 : 0);
         chk("grid menu", int'(menu_on), 1);
      end

      // exit row returns to idle, layers untouched
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 8; k++) tick();
      chk("exit menu", int'(menu_on), 0);
      chk("exit axis", int'(axis_on), 1);
      chk("exit grid", int'(grid_on), 1);
      chk("exit tick", int'(tick_on), 1);

      // timeout cancelled by a coincident button, then taken
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 5; k++) tick();
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk("timeout cancel", int'(menu_on), 1);
      chk("timeout cursor", int'(cursor_pos), 0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("timeout", int'(menu_on), (k < 6) ? 1 : 0);
      end

      // reset in the middle of an axis confirm
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 3; k++) tick();
      chk("confirm axis box", int'(box_flash), 1);
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      chk("abort Axis_On",    int'(axis_on),    1);
      chk("abort Grid_On",    int'(grid_on),    0);
      chk("abort Tick_On",    int'(tick_on),    1);
      chk("abort Welcome_On", int'(welcome_on), 1);
      chk("abort Box_Flash",  int'(box_flash),  0);
      chk("abort Menu_On",    int'(menu_on),    0);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;

      // simultaneous buttons
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("sim pre cursor", int'(cursor_pos), 1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      chk("up+down cursor", int'(cursor_pos), 1);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk("up+centre box", int'(box_flash), 2);
      chk("up+centre cursor", int'(cursor_pos), 1);
      chk("up+centre menu", int'(menu_on), 1);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
